// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer for the 32-bit datapath.
// Generates IR/PC/regfile/data-memory strobes, run control, illegal-op halt and perf counters.
//
// state | meaning
// IDLE  | stopped, waiting for start
// IF    | fetch, latch instruction register
// ID    | decode opcode, trap illegal
// EX    | execute; branches/jumps retire here
// MEM   | data-memory access, held until mem_ready
// WB    | register-file write and PC update
// HALT  | illegal opcode seen; only rstd leaves
module cpu_sequencer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstd,
  input  logic             start,
  input  logic             stop,
  input  logic [5:0]       op,
  input  logic             mem_ready,
  output logic             ir_load,
  output logic             pc_we,
  output logic             rf_wren_n,
  output logic [3:0]       dm_wren_n,
  output logic             mem_req,
  output logic             busy,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_IF   = 3'd1;
  localparam logic [2:0] S_ID   = 3'd2;
  localparam logic [2:0] S_EX   = 3'd3;
  localparam logic [2:0] S_MEM  = 3'd4;
  localparam logic [2:0] S_WB   = 3'd5;
  localparam logic [2:0] S_HALT = 3'd6;

  logic       cls_wb;
  logic       cls_load;
  logic       cls_store;
  logic       cls_branch;
  logic       op_legal;
  logic [3:0] store_lanes;
  logic [2:0] state_nxt;
  logic       set_illegal;
  logic       mem_done;

  // Opcode classes; ALU, LUI and JAL share the writeback path
  always_comb begin
    cls_wb      = 1'b0;
    cls_load    = 1'b0;
    cls_store   = 1'b0;
    cls_branch  = 1'b0;
    store_lanes = 4'b1111;
    case (op)
      6'd0, 6'd1, 6'd3, 6'd4, 6'd5, 6'd6, 6'd41: cls_wb = 1'b1;
      6'd16, 6'd18, 6'd20:                        cls_load = 1'b1;
      6'd24: begin
        cls_store   = 1'b1;
        store_lanes = 4'b0000;
      end
      6'd26: begin
        cls_store   = 1'b1;
        store_lanes = 4'b1100;
      end
      6'd28: begin
        cls_store   = 1'b1;
        store_lanes = 4'b1110;
      end
      6'd32, 6'd33, 6'd34, 6'd35, 6'd40, 6'd42:   cls_branch = 1'b1;
      default: ;
    endcase
  end

  assign op_legal = cls_wb | cls_load | cls_store | cls_branch;
  assign mem_done = (state == S_MEM) && mem_ready;

  always_comb begin
    state_nxt   = state;
    set_illegal = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !stop) state_nxt = S_IF;
      end
      S_IF:   state_nxt = S_ID;
      S_ID: begin
        if (op_legal) begin
          state_nxt = S_EX;
        end else begin
          state_nxt   = S_HALT;
          set_illegal = 1'b1;
        end
      end
      S_EX: begin
        if (cls_branch)                state_nxt = stop ? S_IDLE : S_IF;
        else if (cls_wb)               state_nxt = S_WB;
        else if (cls_load | cls_store) state_nxt = S_MEM;
        else begin
          // opcode changed after decode; treat like a decode trap
          state_nxt   = S_HALT;
          set_illegal = 1'b1;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          if (cls_store) state_nxt = stop ? S_IDLE : S_IF;
          else           state_nxt = S_WB;
        end
      end
      S_WB:   state_nxt = stop ? S_IDLE : S_IF;
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstd) begin
      state   <= S_IDLE;
      illegal <= 1'b0;
    end else begin
      state <= state_nxt;
      if (set_illegal) illegal <= 1'b1;
    end
  end

  always_comb begin
    ir_load   = (state == S_IF);
    rf_wren_n = (state != S_WB);
    mem_req   = (state == S_MEM);
    busy      = (state != S_IDLE) && (state != S_HALT);
    pc_we     = (state == S_WB)
              | ((state == S_EX) & cls_branch)
              | (mem_done & cls_store);
    dm_wren_n = (mem_done && cls_store) ? store_lanes : 4'b1111;
  end

  // Counters wrap freely and only clear on reset
  always_ff @(posedge clk) begin
    if (rstd) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (busy)  cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (pc_we) instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control sequencer for the 32-bit processor datapath (instruction memory, register file, ALU, 4-lane byte-wide data memory, PC register). It steps each instruction through fetch, decode, execute, memory and writeback. It produces the strobes for the instruction register, PC, register file and data-memory lanes, and handshakes with a data memory that may take wait states. It also provides start/stop run control, illegal-opcode halt and two performance counters.

## Interface
Parameters:
- CNT_W, 32, width of cycle and retired-instruction counters.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rstd  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins execution from IDLE.
- stop  in  1  level; finish the current instruction, then return to IDLE.
- op  in  6  opcode field [31:26] of the latched instruction register.
- mem_ready  in  1  data memory completes the current access this cycle.
- ir_load  out  1  latch instruction register.
- pc_we  out  1  load PC with nextpc.
- rf_wren_n  out  1  register-file write enable, active-low.
- dm_wren_n  out  4  data-memory lane write enables, active-low; bit i selects byte lane i.
- mem_req  out  1  data-memory access in progress.
- busy  out  1  high in any state except IDLE and HALT.
- illegal  out  1  sticky flag for an undefined opcode.
- state  out  3  current state: IDLE=0, IF=1, ID=2, EX=3, MEM=4, WB=5, HALT=6.
- cycle_cnt  out  CNT_W  count of cycles spent with busy=1.
- instr_cnt  out  CNT_W  count of retired instructions, equal to the number of pc_we pulses.

## Operation
Opcode classes:
- ALU: 0, 1, 4, 5, 6. LUI: 3. JAL: 41.
- LOAD: 16, 18, 20. STORE: 24 (lanes 4'b0000), 26 (4'b1100), 28 (4'b1110).
- BRANCH/JUMP: 32, 33, 34, 35, 40, 42.
- Any other opcode is illegal.

State transitions:
- IDLE: start=1 and stop=0 -> IF. Otherwise stay in IDLE. If start and stop are both high, stop wins.
- IF: ir_load=1 -> ID.
- ID: illegal opcode -> HALT and set illegal. Otherwise -> EX.
- EX:
  - BRANCH/JUMP: assert pc_we, then go to IDLE if stop is high, else IF.
  - ALU/LUI/JAL -> WB.
  - LOAD/STORE -> MEM.
- MEM: mem_req=1 while waiting for mem_ready.
  - STORE: on the cycle mem_ready=1, drive dm_wren_n with the lane pattern and assert pc_we, then go to IDLE if stop is high, else IF.
  - LOAD: on mem_ready=1 -> WB.
- WB: rf_wren_n=0 and pc_we=1, then go to IDLE if stop is high, else IF. JAL also takes this path and writes register 31.
- HALT: all strobes are deasserted. Only rstd leaves HALT; start is ignored.

General rules:
- The register-file strobe is asserted only in WB. Lane strobes are asserted only in the mem_ready cycle of a store.
- All strobes are Moore outputs of the state, except dm_wren_n and the MEM-state pc_we, which are additionally gated by mem_ready.
- start while busy=1 is ignored.
- stop is sampled only on the instruction-completing edge. A stop pulse that drops before that edge has no effect.
- cycle_cnt increments every cycle with busy=1. instr_cnt increments on every pc_we. Both wrap modulo 2^CNT_W with no saturation. Both hold their value in IDLE and HALT, and clear only on rstd.

## Timing
- Reset values, one edge after rstd=1:
  - state=IDLE, busy=0, illegal=0.
  - ir_load=0, pc_we=0, mem_req=0.
  - rf_wren_n=1, dm_wren_n=4'b1111.
  - both counters=0.
- Reset mid-instruction: strobes are deasserted from the first edge with rstd=1. No partial write occurs after that edge.
- Latency from IF to the next IF (N = wait cycles before mem_ready):
  - BRANCH/JUMP: 3 cycles.
  - ALU/LUI/JAL: 4 cycles.
  - STORE: 4+N cycles.
  - LOAD: 5+N cycles.
- mem_ready is ignored outside MEM. mem_req drops on the edge after mem_ready=1.
- Counter wrap: all-ones +1 -> 0 on the same edge as the increment.

## Test plan
- Reset then start, stream ori, beq, lw (mem_ready tied high) -> state sequence 1,2,3,5 / 1,2,3 / 1,2,3,4,5; instr_cnt=3; cycle_cnt=12.
- sh with mem_ready low for 2 cycles -> mem_req high 3 cycles; dm_wren_n=4'b1100 only in the third; pc_we coincident; all 4'b1111 otherwise.
- Illegal op 6'd63 -> HALT after ID, illegal=1, busy=0. A later start pulse is ignored. rstd clears illegal to 0.
- stop raised during EX of an ALU instruction -> WB completes with rf_wren_n=0 and pc_we=1, then IDLE. start and stop together in IDLE -> stays in IDLE.
- rstd asserted in MEM of a store with mem_ready=1 -> no dm_wren_n low after that edge; state=0 and counters=0 next cycle.
- Preload cycle_cnt near 32'hFFFFFFFF via forced value -> wraps to 0 and continues incrementing.
